// File: rtl/alu_rq_pkg.sv
// -----------------------------------------------------------------------------
// alu_rq_pkg
// Shared definitions for the ALU result queue: flag bit positions, entry
// field widths and the packed FIFO entry layout {inst, flags, data}.
// -----------------------------------------------------------------------------
package alu_rq_pkg;

   localparam int FLAG_OVF = 0;
   localparam int FLAG_C   = 1;
   localparam int FLAG_Z   = 2;
   localparam int FLAG_RSV = 3;

   localparam int DATA_W  = 32;
   localparam int FLAGS_W = 4;
   localparam int INST_W  = 4;
   localparam int ENTRY_W = DATA_W + FLAGS_W + INST_W;

   typedef struct packed {
      logic [INST_W-1:0]  inst;
      logic [FLAGS_W-1:0] flags;
      logic [DATA_W-1:0]  data;
   } alu_rq_entry_t;

   // Keep only the architected flags; the reserved bit never leaves the block.
   function automatic logic [FLAGS_W-1:0] clean_flags(input logic [FLAGS_W-1:0] f);
      logic [FLAGS_W-1:0] r;
      r = '0;
      r[FLAG_OVF] = f[FLAG_OVF];
      r[FLAG_C]   = f[FLAG_C];
      r[FLAG_Z]   = f[FLAG_Z];
      r[FLAG_RSV] = 1'b0;
      return r;
   endfunction

   function automatic alu_rq_entry_t make_entry(input logic [DATA_W-1:0]  data,
                                                input logic [FLAGS_W-1:0] flags,
                                                input logic [INST_W-1:0]  inst);
      alu_rq_entry_t e;
      e.inst  = inst;
      e.flags = clean_flags(flags);
      e.data  = data;
      return e;
   endfunction

endpackage

// File: rtl/alu_rq_fifo.sv
// -----------------------------------------------------------------------------
// alu_rq_fifo
// Generic DEPTH x W storage with wrapping read/write pointers and an occupancy
// counter. Full/empty are derived from the counter, not from pointer compare.
// The caller guarantees no push when full (unless popping) and no pop when
// empty.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (storage, pointers, count)
//   push     in   write wdata at the tail
//   pop      in   retire the head entry
//   wdata    in   W   entry to write
//   rdata    out  W   head entry (mem[rd_ptr])
//   count    out  clog2(DEPTH)+1  occupied entries
//   full     out  count == DEPTH
//   empty    out  count == 0
// -----------------------------------------------------------------------------
module alu_rq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage is reset too so the head reads as zero straight out of reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);

endmodule

// File: rtl/alu_result_queue.sv
// -----------------------------------------------------------------------------
// alu_result_queue
// Captures each valid ALU result {z, flags, inst} into a small FIFO and hands
// it to a consumer over valid/ready. The ALU cannot stall, so results arriving
// while the queue is full (and not draining) are dropped and counted in a
// saturating counter. A sticky register ORs the flags of every accepted result
// since reset or the last sticky_clr.
//
// Build option:
//   ALU_RQ_BYPASS_EN  when defined and the queue is empty, an incoming result
//                     is presented combinationally on out_*; if the consumer
//                     takes it in the same cycle it is never stored.
//                     Undefined (default): one-cycle minimum latency, no
//                     combinational input-to-output path.
//
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   in_valid    in   ALU result valid this cycle
//   z           in   32  ALU result
//   flags       in   4   {rsv, zero, carry, ovf}
//   inst        in   4   opcode tag
//   in_ready    out  queue not full (advisory)
//   out_valid   out  head entry available
//   out_ready   in   consumer accepts head entry
//   out_data    out  32  head result
//   out_flags   out  4   head flags, [3] always 0
//   out_inst    out  4   head opcode tag
//   count       out  clog2(DEPTH)+1  occupied entries
//   sticky      out  4   OR of accepted flags, [3] always 0
//   sticky_clr  in   synchronous clear of sticky
//   drop_cnt    out  CNT_W  saturating count of dropped results
// -----------------------------------------------------------------------------
module alu_result_queue
   import alu_rq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        z,
   input  logic [FLAGS_W-1:0]       flags,
   input  logic [INST_W-1:0]        inst,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [FLAGS_W-1:0]       out_flags,
   output logic [INST_W-1:0]        out_inst,
   output logic [$clog2(DEPTH):0]   count,
   output logic [FLAGS_W-1:0]       sticky,
   input  logic                     sticky_clr,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam logic [CNT_W-1:0] DROP_ONE = CNT_W'(1);

   alu_rq_entry_t in_entry;
   alu_rq_entry_t head_entry;
   alu_rq_entry_t out_entry;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;
   logic bypass;
   logic fifo_push;
   logic fifo_pop;

   assign in_entry = make_entry(z, flags, inst);

`ifdef ALU_RQ_BYPASS_EN
   // While empty, the live input is the head. If the consumer is not ready it
   // is simply stored and re-presented from the FIFO next cycle.
   assign bypass    = empty & in_valid & out_ready;
   assign out_valid = ~empty | in_valid;
   assign out_entry = empty ? in_entry : head_entry;
`else
   assign bypass    = 1'b0;
   assign out_valid = ~empty;
   assign out_entry = head_entry;
`endif

   assign pop  = out_valid & out_ready;
   // A full queue still accepts a result when the head leaves in the same cycle.
   assign push = in_valid & (~full | pop);
   assign drop = in_valid & full & ~pop;

   // A bypassed result counts as pushed and popped but never touches storage.
   assign fifo_push = push & ~bypass;
   assign fifo_pop  = pop & ~bypass;

   alu_rq_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wdata   (in_entry),
      .rdata   (head_entry),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign in_ready  = ~full;
   assign out_data  = out_entry.data;
   assign out_flags = out_entry.flags;
   assign out_inst  = out_entry.inst;

   // Clear and push in the same cycle keep only the new flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sticky <= '0;
      end else begin
         sticky <= (sticky_clr ? '0 : sticky) | (push ? in_entry.flags : '0);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + DROP_ONE;
      end
   end

endmodule

// File: tb/tb_alu_result_queue.sv
module tb_alu_result_queue;

   logic        clock;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] z;
   logic [3:0]  flags;
   logic [3:0]  inst;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;
   logic [3:0]  out_inst;
   logic [2:0]  count;
   logic [3:0]  sticky;
   logic        sticky_clr;
   logic [7:0]  drop_cnt;

   alu_result_queue #(.DEPTH(4), .CNT_W(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .z          (z),
      .flags      (flags),
      .inst       (inst),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_flags  (out_flags),
      .out_inst   (out_inst),
      .count      (count),
      .sticky     (sticky),
      .sticky_clr (sticky_clr),
      .drop_cnt   (drop_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model: a queue of results ----------------
   typedef struct packed {
      logic [3:0]  inst;
      logic [3:0]  flags;
      logic [31:0] data;
   } ent_t;

   ent_t mq[$];
   int   m_sticky;
   int   m_drop;

   task automatic model_clear();
      mq.delete();
      m_sticky = 0;
      m_drop   = 0;
   endtask

   // Apply the current inputs to the model for one clock edge.
   task automatic model_step();
      bit   do_pop, is_full, acc;
      ent_t e;
      do_pop  = (mq.size() > 0) && out_ready;
      is_full = (mq.size() == 4);
      acc     = in_valid && (!is_full || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (acc) begin
         e.inst  = inst;
         e.flags = flags & 4'b0111;
         e.data  = z;
         mq.push_back(e);
      end else if (in_valid && m_drop < 255) begin
         m_drop++;
      end
      m_sticky = (sticky_clr ? 0 : m_sticky) | (acc ? int'(flags & 4'b0111) : 0);
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".count"},     count,     mq.size());
      chk({tag, ".out_valid"}, out_valid, mq.size() != 0);
      chk({tag, ".in_ready"},  in_ready,  mq.size() < 4);
      chk({tag, ".sticky"},    sticky,    m_sticky);
      chk({tag, ".drop_cnt"},  drop_cnt,  m_drop);
      if (mq.size() > 0) begin
         chk({tag, ".out_data"},  out_data,  mq[0].data);
         chk({tag, ".out_flags"}, out_flags, mq[0].flags);
         chk({tag, ".out_inst"},  out_inst,  mq[0].inst);
      end
   endtask

   // Inputs are set at posedge+1; this advances one edge and checks.
   task automatic tick(input string tag);
      model_step();
      @(posedge clock);
      #1;
      compare_model(tag);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".count"},     count,     0);
      chk({tag, ".out_valid"}, out_valid, 0);
      chk({tag, ".in_ready"},  in_ready,  1);
      chk({tag, ".sticky"},    sticky,    0);
      chk({tag, ".drop_cnt"},  drop_cnt,  0);
      chk({tag, ".out_data"},  out_data,  0);
      chk({tag, ".out_flags"}, out_flags, 0);
      chk({tag, ".out_inst"},  out_inst,  0);
   endtask

   task automatic do_reset();
      #1 reset_n = 1'b0;
      #1 check_reset_values("reset");
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      model_clear();
   endtask

   task automatic idle_inputs();
      in_valid   = 1'b0;
      z          = '0;
      flags      = '0;
      inst       = '0;
      out_ready  = 1'b0;
      sticky_clr = 1'b0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        iv;
      logic [31:0] z;
      logic [3:0]  f;
      logic [3:0]  inst;
      logic        rdy;
      logic        clr;
      int          cnt;
      logic        ov;
      logic [31:0] data;
      logic [3:0]  oflags;
      logic [3:0]  oinst;
      logic [3:0]  sticky;
      int          drop;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic [31:0] zz, logic [3:0] f, logic [3:0] in,
                               logic rdy, logic clr, int cnt, logic ov, logic [31:0] d,
                               logic [3:0] of, logic [3:0] oi, logic [3:0] st, int dr);
      vec_t v;
      v.iv = iv; v.z = zz; v.f = f; v.inst = in; v.rdy = rdy; v.clr = clr;
      v.cnt = cnt; v.ov = ov; v.data = d; v.oflags = of; v.oinst = oi;
      v.sticky = st; v.drop = dr;
      return v;
   endfunction

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      model_clear();

      //             iv z   f        in rdy clr  cnt ov data fl       in st       drop
      tbl.push_back(mk(1, 5,  4'b0000, 2, 1, 0,  1, 1, 5,  4'b0000, 2, 4'b0000, 0));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  0, 0, 0,  4'b0000, 0, 4'b0000, 0));
      tbl.push_back(mk(1, 1,  4'b0000, 1, 0, 0,  1, 1, 1,  4'b0000, 1, 4'b0000, 0));
      tbl.push_back(mk(1, 2,  4'b0000, 2, 0, 0,  2, 1, 1,  4'b0000, 1, 4'b0000, 0));
      tbl.push_back(mk(1, 3,  4'b0000, 3, 0, 0,  3, 1, 1,  4'b0000, 1, 4'b0000, 0));
      tbl.push_back(mk(1, 4,  4'b0000, 4, 0, 0,  4, 1, 1,  4'b0000, 1, 4'b0000, 0));
      tbl.push_back(mk(1, 5,  4'b0000, 5, 0, 0,  4, 1, 1,  4'b0000, 1, 4'b0000, 1));
      tbl.push_back(mk(1, 6,  4'b0000, 6, 0, 0,  4, 1, 1,  4'b0000, 1, 4'b0000, 2));
      tbl.push_back(mk(1, 7,  4'b0000, 7, 1, 0,  4, 1, 2,  4'b0000, 2, 4'b0000, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  3, 1, 3,  4'b0000, 3, 4'b0000, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  2, 1, 4,  4'b0000, 4, 4'b0000, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  1, 1, 7,  4'b0000, 7, 4'b0000, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  0, 0, 0,  4'b0000, 0, 4'b0000, 2));
      tbl.push_back(mk(1, 8,  4'b0001, 3, 1, 0,  1, 1, 8,  4'b0001, 3, 4'b0001, 2));
      tbl.push_back(mk(1, 9,  4'b0100, 3, 1, 0,  1, 1, 9,  4'b0100, 3, 4'b0101, 2));
      tbl.push_back(mk(1, 10, 4'b1010, 3, 1, 0,  1, 1, 10, 4'b0010, 3, 4'b0111, 2));
      tbl.push_back(mk(1, 11, 4'b0010, 3, 1, 1,  1, 1, 11, 4'b0010, 3, 4'b0010, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 1, 0,  0, 0, 0,  4'b0000, 0, 4'b0010, 2));
      tbl.push_back(mk(0, 0,  4'b0000, 0, 0, 1,  0, 0, 0,  4'b0000, 0, 4'b0000, 2));

      #2 check_reset_values("por");
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;

      foreach (tbl[i]) begin
         in_valid   = tbl[i].iv;
         z          = tbl[i].z;
         flags      = tbl[i].f;
         inst       = tbl[i].inst;
         out_ready  = tbl[i].rdy;
         sticky_clr = tbl[i].clr;
         @(posedge clock);
         #1;
         chk($sformatf("tbl%0d.count", i),     count,     tbl[i].cnt);
         chk($sformatf("tbl%0d.out_valid", i), out_valid, tbl[i].ov);
         chk($sformatf("tbl%0d.in_ready", i),  in_ready,  tbl[i].cnt < 4);
         chk($sformatf("tbl%0d.sticky", i),    sticky,    tbl[i].sticky);
         chk($sformatf("tbl%0d.drop_cnt", i),  drop_cnt,  tbl[i].drop);
         if (tbl[i].ov) begin
            chk($sformatf("tbl%0d.out_data", i),  out_data,  tbl[i].data);
            chk($sformatf("tbl%0d.out_flags", i), out_flags, tbl[i].oflags);
            chk($sformatf("tbl%0d.out_inst", i),  out_inst,  tbl[i].oinst);
         end
      end
      idle_inputs();

      // ---------------- randomized traffic vs. model ----------------
      do_reset();
      for (int c = 0; c < 600; c++) begin
         in_valid   = ($urandom_range(0, 9) < 7);
         z          = $urandom;
         flags      = 4'($urandom_range(0, 15));
         inst       = 4'($urandom_range(0, 15));
         out_ready  = ($urandom_range(0, 9) < (c < 300 ? 4 : 6));
         sticky_clr = ($urandom_range(0, 19) == 0);
         tick("rand");
      end

      // ---------------- drop counter saturation ----------------
      sticky_clr = 1'b0;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      for (int c = 0; c < 304; c++) begin
         z     = 32'(c);
         flags = 4'($urandom_range(0, 15));
         tick("sat");
      end
      chk("drop_sat", drop_cnt, 8'hFF);

      // ---------------- async reset with 3 entries queued ----------------
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) tick("drain");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         z     = 32'(100 + c);
         flags = 4'b0011;
         inst  = 4'(c);
         tick("fill3");
      end
      in_valid = 1'b0;
      chk("mid.count_before", count, 3);
      #2 reset_n = 1'b0;
      #1;
      chk("mid.out_valid", out_valid, 0);
      chk("mid.count",     count,     0);
      chk("mid.sticky",    sticky,    0);
      chk("mid.drop_cnt",  drop_cnt,  0);
      chk("mid.in_ready",  in_ready,  1);
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      model_clear();
      compare_model("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the 32-bit ALU: captures each valid ALU result (Z, FLAGS, and the INST that produced it) into a small FIFO and presents it to a consumer (register-file writeback or bus master) over a valid/ready handshake. It keeps a sticky-flag register accumulating ALU flags since last clear, and counts results dropped on overflow. The ALU has no stall input, so this block absorbs consumer back-pressure.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥2
- CNT_W, 8, width of the saturating drop counter
- CLOCK  in  1  rising-edge clock, the block's only clock
- RESET_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  ALU result on Z/FLAGS/INST is valid this cycle
- Z  in  32  ALU result
- FLAGS  in  4  ALU flags: [0] OVF, [1] carry, [2] zero, [3] reserved
- INST  in  4  opcode that produced Z, carried as tag
- IN_READY  out  1  FIFO not full (advisory; ALU cannot stall)
- OUT_VALID  out  1  head entry available
- OUT_READY  in  1  consumer accepts head entry
- OUT_DATA  out  32  head result
- OUT_FLAGS  out  4  head flags, [3] always 0
- OUT_INST  out  4  head opcode tag
- COUNT  out  clog2(DEPTH)+1  occupied entries
- STICKY  out  4  OR of flags of all accepted results since reset/clear, [3] always 0
- STICKY_CLR  in  1  synchronous clear of STICKY
- DROP_CNT  out  CNT_W  results lost while full, saturating

## Operation
- Push = IN_VALID & (not full | pop); pop = OUT_VALID & OUT_READY.
- Drop = IN_VALID & full & ~pop: entry discarded, DROP_CNT += 1, saturates at all-ones, never wraps; STICKY not updated by dropped results.
- Full with simultaneous push and pop: both occur, COUNT unchanged, no drop.
- Empty with pop: impossible (OUT_VALID low); push alone only.
- FLAGS[3] is stored as 0 regardless of input.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty come from COUNT, not pointer compare.
- STICKY next = (STICKY_CLR ? 0 : STICKY) | (push ? FLAGS & 4'b0111 : 0); clear and push in the same cycle leaves only the new flags.
- OUT_DATA/OUT_FLAGS/OUT_INST hold stable while OUT_VALID & ~OUT_READY; their values are don't-care while OUT_VALID is low.

## Timing
- Reset (asynchronous assert, synchronous release via the flops): COUNT 0, OUT_VALID 0, IN_READY 1, STICKY 0, DROP_CNT 0, OUT_DATA 0, OUT_FLAGS 0, OUT_INST 0, pointers 0. Reset mid-stream discards all entries; no partial pop.
- Latency: result pushed at edge N appears on OUT_* with OUT_VALID high after edge N (one cycle), when the FIFO was empty.
- IN_READY, OUT_VALID, COUNT, STICKY, DROP_CNT are registered-state derived; no combinational path IN_VALID→OUT_VALID (unless bypass is compiled in).
- Sustained throughput: one push and one pop per cycle.

## Configuration
- ALU_RQ_BYPASS_EN defined: when COUNT==0, IN_VALID and OUT_READY, the input passes combinationally to OUT_* with OUT_VALID high, and is consumed without being stored (COUNT stays 0); STICKY still updates. Zero-cycle latency when empty.
- Not defined: no combinational input-to-output path; minimum latency one cycle.

## Structure
- Package alu_rq_pkg: flag bit index constants (FLAG_OVF=0, FLAG_C=1, FLAG_Z=2, FLAG_RSV=3), entry width constant (40 = 32+4+4), and a packed entry struct {inst, flags, data}.
- Sub-module alu_rq_fifo: generic DEPTH×entry storage with read/write pointers and COUNT; alu_result_queue adds handshake, drop counter, sticky flags, bypass.

## Test plan
- Reset then IN_VALID one cycle with Z=32'h0000_0005, FLAGS=4'b0000, INST=4'b0010, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=5, OUT_INST=2; following cycle COUNT=0 (bypass build: OUT_VALID same cycle).
- OUT_READY=0, six consecutive pushes Z=1..6 with DEPTH=4 -> IN_READY=0 after 4, DROP_CNT=2, then draining yields 1,2,3,4 in order.
- Full FIFO, IN_VALID and OUT_READY both high -> push accepted, DROP_CNT unchanged, COUNT stays 4.
- Pushes with FLAGS 4'b0001 then 4'b0100, then FLAGS 4'b1010 -> STICKY=4'b0111; STICKY_CLR with push FLAGS=4'b0010 -> STICKY=4'b0010.
- 300 drops with CNT_W=8 -> DROP_CNT=8'hFF, no wrap.
- RESET_N pulsed low mid-cycle with COUNT=3 -> immediately OUT_VALID=0, COUNT=0, STICKY=0, DROP_CNT=0, without waiting for CLOCK.
